// File: rtl/mac_result_serializer_if.sv
// Valid/ready bundle between the MAC array's result bus, the serializer and the writeback path.
// Input side carries a whole N-lane vector; output side carries one lane per beat.
interface mac_result_serializer_if #(
    parameter int WIDTH = 8,
    parameter int N     = 16
);
    localparam int LW = (N > 1) ? $clog2(N) : 1;

    logic                          in_valid;
    logic                          in_ready;
    logic [N-1:0][2*WIDTH-1:0]     in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [2*WIDTH-1:0]            out_data;
    logic [LW-1:0]                 out_lane;
    logic                          out_last;

    // Serializer side: consumes vectors, produces beats.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_lane, out_last
    );

    // Surrounding side: the array upstream and writeback downstream.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_lane, out_last
    );
endinterface

// File: rtl/mac_result_serializer.sv
// Serializes N-lane MAC result vectors into one lane per beat, lane 0 first.
// One active vector is being drained while at most one more waits in the pending slot.
module mac_result_serializer #(
    parameter int WIDTH = 8,
    parameter int N     = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mac_result_serializer_if.slave  bus,
    output logic                    busy
);
    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = 2 * WIDTH;
    localparam logic [LW-1:0] LAST_LANE = LW'(N - 1);

    // Encoding is {pending_valid, active_valid}.
    typedef enum logic [1:0] {
        ST_EMPTY      = 2'b00,
        ST_DRAIN      = 2'b01,
        ST_DRAIN_PEND = 2'b11
    } state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          lane_q, lane_d;
    logic [N-1:0][DW-1:0]   active_q, active_d;
    logic [N-1:0][DW-1:0]   pending_q, pending_d;
    logic [DW-1:0]          lane_data;

    logic accept;
    logic xfer;
    logic at_last;
    logic last_xfer;

    assign bus.in_ready  = (state_q != ST_DRAIN_PEND);
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign busy          = (state_q != ST_EMPTY);

    assign accept    = bus.in_valid & bus.in_ready;
    assign xfer      = bus.out_valid & bus.out_ready;
    assign at_last   = (lane_q == LAST_LANE);
    assign last_xfer = xfer & at_last;

    generate
        if (N == 1) begin : g_single
            assign lane_data = active_q[0];
        end else begin : g_multi
            assign lane_data = active_q[lane_q];
        end
    endgenerate

    // Stale buffer contents survive reset, so gate them off while empty.
    assign bus.out_data = bus.out_valid ? lane_data : '0;
    assign bus.out_lane = lane_q;
    assign bus.out_last = bus.out_valid & at_last;

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        active_d  = active_q;
        pending_d = pending_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    active_d = bus.in_data;
                    lane_d   = '0;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (xfer) begin
                    lane_d = at_last ? '0 : lane_q + LW'(1);
                end
                if (last_xfer) begin
                    // A vector arriving with the last beat goes straight to active: no bubble.
                    if (accept) begin
                        active_d = bus.in_data;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end else if (accept) begin
                    pending_d = bus.in_data;
                    state_d   = ST_DRAIN_PEND;
                end
            end
            ST_DRAIN_PEND: begin
                if (xfer) begin
                    lane_d = at_last ? '0 : lane_q + LW'(1);
                end
                if (last_xfer) begin
                    active_d = pending_q;
                    state_d  = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                lane_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
        end
    end

    // Vector storage is qualified by state, so it needs no reset.
    always_ff @(posedge clk) begin
        active_q  <= active_d;
        pending_q <= pending_d;
    end
endmodule
